bus_dma: RTL and testbench

Word-granular DMA engine acting as a second initiator on the core data bus. It copies `len` 32-bit words from one word address to another, or fills a range with a constant word. It uses the same bus signalling as the core: lock, mode, 30-bit word address, byte mask, write data, and read data returned one enabled cycle later from the registered BRAM buffer. It sits beside the core behind a toplevel bus arbiter that owns `bus_grant`.

---
 rtl/srv1_bus_pkg.sv | 26 ++
 rtl/bus_dma_if.sv | 41 ++++
 rtl/bus_dma.sv | 163 ++++++++++++++++
 tb/tb_bus_dma.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srv1_bus_pkg.sv
// Shared definitions for initiators on the core data bus.
//   BUS_ADDR_W / BUS_DATA_W : word-address and data widths
//   MASK_WORD               : byte enables for a full-word access
//   dma_state_t             : state encoding of the DMA controller
//   addr_inc                : word-address increment, wraps modulo 2^BUS_ADDR_W
package srv1_bus_pkg;

    localparam int BUS_ADDR_W = 30;
    localparam int BUS_DATA_W = 32;

    localparam logic [3:0] MASK_WORD = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } dma_state_t;

    // Carry out of the top bit is dropped, so the address simply wraps.
    function automatic logic [BUS_ADDR_W-1:0] addr_inc(input logic [BUS_ADDR_W-1:0] addr);
        return addr + BUS_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/bus_dma_if.sv
// Core data bus as seen by one initiator.
//   bus_grant    : arbiter permits an access this cycle (slave -> master)
//   bus_lock     : access request                       (master -> slave)
//   memory_mode  : 0 = read, 1 = write                  (master -> slave)
//   data_address : word address                         (master -> slave)
//   data_mask    : byte enables                         (master -> slave)
//   data_out     : write data                           (master -> slave)
//   data_in      : read data, one enabled cycle after an accepted read
//                                                       (slave -> master)
interface bus_dma_if;
    import srv1_bus_pkg::*;

    logic                  bus_grant;
    logic                  bus_lock;
    logic                  memory_mode;
    logic [BUS_ADDR_W-1:0] data_address;
    logic [3:0]            data_mask;
    logic [BUS_DATA_W-1:0] data_out;
    logic [BUS_DATA_W-1:0] data_in;

    modport master (
        input  bus_grant,
        input  data_in,
        output bus_lock,
        output memory_mode,
        output data_address,
        output data_mask,
        output data_out
    );

    modport slave (
        output bus_grant,
        output data_in,
        input  bus_lock,
        input  memory_mode,
        input  data_address,
        input  data_mask,
        input  data_out
    );

endinterface

// File: rtl/bus_dma.sv
// Word-granular DMA engine: copies len words from src_addr to dst_addr, or
// fills len words at dst_addr with fill_word, as a second initiator on the
// core data bus.
//   clk, sync_rst  : clock and synchronous active-high reset
//   clk_en         : global enable; nothing changes while low
//   start          : launch request, honoured in IDLE only
//   fill_mode      : 0 = copy, 1 = fill (sampled with start)
//   src_addr       : copy source word address (sampled with start)
//   dst_addr       : destination word address (sampled with start)
//   len            : word count, 0 completes with no bus traffic
//   fill_word      : fill pattern (sampled with start)
//   busy           : high in every state except IDLE
//   done           : one enabled-cycle pulse at the end of a transfer
//   bus            : bus_dma_if master modport
module bus_dma
    import srv1_bus_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  sync_rst,
    input  logic                  clk_en,
    input  logic                  start,
    input  logic                  fill_mode,
    input  logic [BUS_ADDR_W-1:0] src_addr,
    input  logic [BUS_ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]      len,
    input  logic [BUS_DATA_W-1:0] fill_word,
    output logic                  busy,
    output logic                  done,
    bus_dma_if.master             bus
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_READ  = 3'(READ);
    localparam logic [2:0] S_LATCH = 3'(LATCH);
    localparam logic [2:0] S_WRITE = 3'(WRITE);
    localparam logic [2:0] S_DONE  = 3'(DONE);

    logic [2:0]            state_reg,  state_next;
    logic [BUS_ADDR_W-1:0] src_reg,    src_next;
    logic [BUS_ADDR_W-1:0] dst_reg,    dst_next;
    logic [LEN_W-1:0]      count_reg,  count_next;
    logic [BUS_DATA_W-1:0] word_reg,   word_next;
    logic [BUS_DATA_W-1:0] fill_reg,   fill_next;
    logic                  mode_reg,   mode_next;

    // Next-state and datapath update.
    always_comb begin
        state_next = state_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        count_next = count_reg;
        word_next  = word_reg;
        fill_next  = fill_reg;
        mode_next  = mode_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    src_next   = src_addr;
                    dst_next   = dst_addr;
                    count_next = len;
                    fill_next  = fill_word;
                    mode_next  = fill_mode;
                    if (len == '0) begin
                        state_next = S_DONE;
                    end else if (fill_mode) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end

            S_READ: begin
                if (bus.bus_grant) begin
                    state_next = S_LATCH;
                end
            end

            // The read was accepted last cycle, so the data is already on
            // data_in; no grant is needed here.
            S_LATCH: begin
                word_next  = bus.data_in;
                state_next = S_WRITE;
            end

            S_WRITE: begin
                if (bus.bus_grant) begin
                    dst_next   = addr_inc(dst_reg);
                    count_next = count_reg - LEN_W'(1);
                    if (!mode_reg) begin
                        src_next = addr_inc(src_reg);
                    end
                    if (count_reg == LEN_W'(1)) begin
                        state_next = S_DONE;
                    end else if (!mode_reg) begin
                        state_next = S_READ;
                    end
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_reg <= S_IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            count_reg <= '0;
            word_reg  <= '0;
            fill_reg  <= '0;
            mode_reg  <= 1'b0;
        end else if (clk_en) begin
            state_reg <= state_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            count_reg <= count_next;
            word_reg  <= word_next;
            fill_reg  <= fill_next;
            mode_reg  <= mode_next;
        end
    end

    // Bus outputs are decoded from state; everything is zero outside
    // READ/WRITE so the bus is quiet in idle, latch and done.
    always_comb begin
        bus.bus_lock     = 1'b0;
        bus.memory_mode  = 1'b0;
        bus.data_address = '0;
        bus.data_mask    = 4'h0;
        bus.data_out     = '0;

        case (state_reg)
            S_READ: begin
                bus.bus_lock     = bus.bus_grant;
                bus.data_address = src_reg;
            end
            S_WRITE: begin
                bus.bus_lock     = bus.bus_grant;
                bus.memory_mode  = 1'b1;
                bus.data_mask    = MASK_WORD;
                bus.data_address = dst_reg;
                bus.data_out     = mode_reg ? fill_reg : word_reg;
            end
            default: begin
            end
        endcase
    end

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);

endmodule

// File: tb/tb_bus_dma.sv
module tb_bus_dma;
    import srv1_bus_pkg::*;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        clk_en;
    logic        start;
    logic        fill_mode;
    logic [29:0] src_addr;
    logic [29:0] dst_addr;
    logic [15:0] len;
    logic [31:0] fill_word;
    logic        busy;
    logic        done;

    bus_dma_if bus_if ();

    bus_dma #(.LEN_W(16)) dut (
        .clk       (clk),
        .sync_rst  (sync_rst),
        .clk_en    (clk_en),
        .start     (start),
        .fill_mode (fill_mode),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len       (len),
        .fill_word (fill_word),
        .busy      (busy),
        .done      (done),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_run = 0;
    int done_seen = 0;
    int lock_cycles = 0;
    bit fill_active = 1'b0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int lat;
        int busy_en;
    } done_t;

    wr_t   exp_wr[$];
    done_t exp_done[$];
    wr_t   w;
    done_t d;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wr(input logic [29:0] a, input logic [31:0] v);
        wr_t e;
        e.addr = a;
        e.data = v;
        exp_wr.push_back(e);
    endtask

    task automatic push_done(input int lat, input int busy_en);
        done_t e;
        e.lat = lat;
        e.busy_en = busy_en;
        exp_done.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    logic [31:0] mem [logic [29:0]];

    always @(posedge clk) begin
        if (clk_en && bus_if.bus_lock) begin
            if (bus_if.memory_mode) begin
                mem[bus_if.data_address] = bus_if.data_out;
            end else begin
                bus_if.data_in <= mem.exists(bus_if.data_address) ? mem[bus_if.data_address] : 32'h0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!sync_rst) begin
            if (bus_if.bus_lock) begin
                lock_cycles++;
                check("lock_needs_grant", {63'd0, bus_if.bus_grant}, 64'd1);
                if (fill_active) check("fill_no_read", {63'd0, bus_if.memory_mode}, 64'd1);
            end
            if (!busy) check("idle_quiet", {62'd0, bus_if.bus_lock, done}, 64'd0);

            if (clk_en && bus_if.bus_lock && bus_if.memory_mode) begin
                if (exp_wr.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus_if.data_address, bus_if.data_out);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", 64'(bus_if.data_address), 64'(w.addr));
                    check("wr_data", 64'(bus_if.data_out), 64'(w.data));
                    check("wr_mask", 64'(bus_if.data_mask), 64'h0F);
                    $display("[TB] write addr=0x%08h data=0x%08h", bus_if.data_address, bus_if.data_out);
                end
            end

            if (clk_en) busy_run = busy ? busy_run + 1 : 0;

            if (clk_en && done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done high, expected no done");
                end else begin
                    d = exp_done.pop_front();
                    check("done_latency", 64'(cyc - start_cyc + 1), 64'(d.lat));
                    check("busy_cycles", 64'(busy_run), 64'(d.busy_en));
                    $display("[TB] done latency=%0d busy=%0d", cyc - start_cyc + 1, busy_run);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at #1 after a posedge; returns at #1 after edge T (start sampled).
    task automatic launch(input bit fm, input logic [29:0] s, input logic [29:0] dd,
                          input logic [15:0] n, input logic [31:0] fw);
        fill_mode = fm;
        src_addr  = s;
        dst_addr  = dd;
        len       = n;
        fill_word = fw;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int i = 0; i < budget && done_seen == base; i++) @(posedge clk);
        check("done_seen", 64'(done_seen - base), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int lc;

        sync_rst = 1'b1;
        clk_en = 1'b1;
        start = 1'b0;
        fill_mode = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        fill_word = '0;
        bus_if.bus_grant = 1'b1;
        mem[30'h10] = 32'h11111111;
        mem[30'h11] = 32'h22222222;
        mem[30'h12] = 32'h33333333;
        mem[30'h13] = 32'h44444444;

        repeat (3) @(posedge clk);
        #1;
        sync_rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_lock_mode", {62'd0, bus_if.bus_lock, bus_if.memory_mode}, 64'd0);
        check("rst_addr", 64'(bus_if.data_address), 64'd0);
        check("rst_mask", 64'(bus_if.data_mask), 64'd0);
        check("rst_data", 64'(bus_if.data_out), 64'd0);
        @(posedge clk);
        #1;

        // Copy 4 words, grant always high: 3 cycles/word + done.
        push_wr(30'h100, 32'h11111111);
        push_wr(30'h101, 32'h22222222);
        push_wr(30'h102, 32'h33333333);
        push_wr(30'h103, 32'h44444444);
        push_done(13, 13);
        base = done_seen;
        launch(1'b0, 30'h10, 30'h100, 16'd4, 32'h0);
        wait_done(base, 40);

        // Fill 3 words.
        fill_active = 1'b1;
        push_wr(30'h20, 32'hDEADBEEF);
        push_wr(30'h21, 32'hDEADBEEF);
        push_wr(30'h22, 32'hDEADBEEF);
        push_done(4, 4);
        base = done_seen;
        launch(1'b1, 30'h0, 30'h20, 16'd3, 32'hDEADBEEF);
        wait_done(base, 20);
        fill_active = 1'b0;

        // len = 0: done next cycle, no bus traffic.
        lc = lock_cycles;
        push_done(1, 1);
        base = done_seen;
        launch(1'b0, 30'h10, 30'h400, 16'd0, 32'h0);
        wait_done(base, 10);
        check("len0_no_bus", 64'(lock_cycles - lc), 64'd0);

        // Destination address wraps to 0.
        push_wr(30'h3FFFFFFF, 32'h5A5A5A5A);
        push_wr(30'h00000000, 32'h5A5A5A5A);
        push_done(3, 3);
        base = done_seen;
        launch(1'b1, 30'h0, 30'h3FFFFFFF, 16'd2, 32'h5A5A5A5A);
        wait_done(base, 20);

        // Second start while busy is ignored.
        push_wr(30'h40, 32'hCAFEF00D);
        push_wr(30'h41, 32'hCAFEF00D);
        push_wr(30'h42, 32'hCAFEF00D);
        push_done(4, 4);
        base = done_seen;
        launch(1'b1, 30'h0, 30'h40, 16'd3, 32'hCAFEF00D);
        dst_addr  = 30'h50;
        fill_word = 32'h12345678;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(base, 20);
        idle(6);

        // Grant toggling 0,1,0,1,... from the first READ cycle: two
        // grant-low READ cycles add two cycles to the nominal 7.
        push_wr(30'h180, 32'h33333333);
        push_wr(30'h181, 32'h44444444);
        push_done(9, 9);
        base = done_seen;
        launch(1'b0, 30'h12, 30'h180, 16'd2, 32'h0);
        for (int i = 0; i < 12; i++) begin
            bus_if.bus_grant = (i % 2 == 1);
            @(posedge clk);
            #1;
        end
        bus_if.bus_grant = 1'b1;
        check("throttle_done_seen", 64'(done_seen - base), 64'd1);
        idle(2);

        // clk_en low for 5 cycles in the first WRITE: outputs hold.
        push_wr(30'h200, 32'h11111111);
        push_wr(30'h201, 32'h22222222);
        push_done(12, 7);
        base = done_seen;
        launch(1'b0, 30'h10, 30'h200, 16'd2, 32'h0);
        idle(2);
        clk_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("frz_busy_lock_mode", {61'd0, busy, bus_if.bus_lock, bus_if.memory_mode}, 64'd7);
            check("frz_addr", 64'(bus_if.data_address), 64'h200);
            check("frz_data", 64'(bus_if.data_out), 64'h11111111);
            check("frz_mask", 64'(bus_if.data_mask), 64'hF);
            @(posedge clk);
            #1;
        end
        clk_en = 1'b1;
        wait_done(base, 30);

        // Reset in the second LATCH: only the first word lands.
        push_wr(30'h300, 32'h11111111);
        launch(1'b0, 30'h10, 30'h300, 16'd3, 32'h0);
        idle(4);
        @(negedge clk);
        check("pre_rst_latch", {62'd0, busy, bus_if.bus_lock}, 64'd2);
        #1;
        sync_rst = 1'b1;
        @(posedge clk);
        #1;
        sync_rst = 1'b0;
        @(negedge clk);
        check("abort_busy_done", {62'd0, busy, done}, 64'd0);
        check("abort_lock_mode", {62'd0, bus_if.bus_lock, bus_if.memory_mode}, 64'd0);
        check("abort_addr", 64'(bus_if.data_address), 64'd0);
        check("abort_data", 64'(bus_if.data_out), 64'd0);
        check("abort_mask", 64'(bus_if.data_mask), 64'd0);
        idle(8);

        // Recovery after abort.
        push_wr(30'h60, 32'h0BADF00D);
        push_done(2, 2);
        base = done_seen;
        launch(1'b1, 30'h0, 30'h60, 16'd1, 32'h0BADF00D);
        wait_done(base, 20);
        idle(4);

        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("done_queue_drained", 64'(exp_done.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
